out_port_uart_tx: RTL and testbench

//  Peripheral on the device side of a microcontroller output port. The CPU writes bytes with a one-cycle

---
 rtl/out_port_uart_tx.sv | 100 ++++++++++
 tb/tb_out_port_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: CPU output-port UART transmitter with a small byte FIFO and a pollable status byte.
// Frames are start bit, WIDTH data bits LSB first, one stop bit; back-to-back frames have no idle gap.
module out_port_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic             tx,
    output logic [WIDTH-1:0] status
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [AW-1:0]    wr_q, rd_q;
    logic [NW-1:0]    cnt_q;
    logic             ovf_q, ovf_d, tx_q, tx_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full, empty, busy, baud_done, last_bit, pop, push, drop;

    assign full      = cnt_q == NW'(DEPTH);
    assign empty     = cnt_q == '0;
    assign busy      = (state_q != IDLE) || !empty;
    assign baud_done = baud_q == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = idx_q == IW'(WIDTH - 1);
    // A frame is loaded from idle, or straight out of a finishing stop bit
    assign pop       = !empty && (state_q == IDLE || (state_q == STOP && baud_done));
    assign push      = we && (!full || pop);
    assign drop      = we && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : START;
            START:   state_d = baud_done ? DATA : START;
            DATA:    state_d = (baud_done && last_bit) ? STOP : DATA;
            STOP:    state_d = baud_done ? (empty ? IDLE : START) : STOP;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM
    always_comb begin
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    always_comb begin
        baud_d  = (state_q == IDLE || baud_done) ? '0 : baud_q + 1'b1;
        idx_d   = (state_q != DATA) ? '0 : !baud_done ? idx_q : last_bit ? '0 : idx_q + 1'b1;
        shift_d = pop ? mem[rd_q] : (state_q == DATA && baud_done) ? shift_q >> 1 : shift_q;
        ovf_d   = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= d;
    end

    assign tx     = tx_q;
    assign status = {{(WIDTH - 4){1'b0}}, ovf_q, empty, full, busy};
endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: scenario and randomized checks of the UART transmitter against a frame-position model.
module tb_out_port_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset, we, clr_ovf;
    logic [7:0] d;
    logic       tx;
    logic [7:0] status;

    int tests = 0;
    int fails = 0;

    // Model: byte queue, position inside the current frame (-1 = line idle), sticky overflow
    logic [7:0] q[$];
    logic [7:0] cur;
    int         pos;
    logic       ovf_m;

    out_port_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .we(we), .d(d), .clr_ovf(clr_ovf), .tx(tx), .status(status)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        q.delete();
        pos = -1;
        cur = 8'h00;
        ovf_m = 1'b0;
    endtask

    task automatic m_step();
        logic pop_now, drop_now;
        pop_now  = (pos < 0 || pos == FRAME - 1) && q.size() > 0;
        drop_now = we && q.size() == DEPTH && !pop_now;
        if (pop_now) begin
            cur = q.pop_front();
            pos = 0;
        end else if (pos == FRAME - 1) pos = -1;
        else if (pos >= 0) pos++;
        if (we && !drop_now) q.push_back(d);
        ovf_m = drop_now ? 1'b1 : clr_ovf ? 1'b0 : ovf_m;
    endtask

    function automatic logic m_tx();
        if (pos < 0) return 1'b1;
        if (pos < CPB) return 1'b0;
        if (pos < 9 * CPB) return cur[(pos - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0, ovf_m, q.size() == 0, q.size() == DEPTH, pos >= 0 || q.size() != 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else m_step();
        #1;
    endtask

    task automatic test_reset();
        tests += 2;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
        if (status !== 8'h04) begin fails++; $display("FAIL reset_status got %h want 04", status); end
        we = 1'b1; d = 8'h5A; tick(); we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL rst_pre_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL rst_pre_status cyc %0d got %h want %h", i, status, m_status()); end
        end
        #2 reset = 1'b1;
        m_reset();
        #1;
        tests += 2;
        if (tx !== 1'b1) begin fails++; $display("FAIL async_rst_tx got %b want 1", tx); end
        if (status !== 8'h04) begin fails++; $display("FAIL async_rst_status got %h want 04", status); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL rst_post_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL rst_post_status cyc %0d got %h want %h", i, status, m_status()); end
        end
    endtask

    task automatic test_single();
        we = 1'b1; d = 8'hA5; tick(); we = 1'b0;
        tests++;
        if (status[0] !== 1'b1) begin fails++; $display("FAIL single_busy_at_write got %b want 1", status[0]); end
        for (int i = 0; i < FRAME + 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL single_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL single_status cyc %0d got %h want %h", i, status, m_status()); end
        end
        tests++;
        if (status !== 8'h04) begin fails++; $display("FAIL single_end_status got %h want 04", status); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2] = '{8'h00, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            we = 1'b1; d = bytes[i]; tick();
        end
        we = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL b2b_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL b2b_status cyc %0d got %h want %h", i, status, m_status()); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            we = 1'b1; d = 8'(i); tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL ovf_fill_tx wr %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL ovf_fill_status wr %0d got %h want %h", i, status, m_status()); end
            if (i == 5) begin
                tests++;
                if (status[1] !== 1'b1) begin fails++; $display("FAIL ovf_full_after_5 got %b want 1", status[1]); end
            end
            if (i == 6) begin
                tests++;
                if (status[3] !== 1'b1) begin fails++; $display("FAIL ovf_set_after_6 got %b want 1", status[3]); end
            end
        end
        we = 1'b0;
        for (int i = 0; i < 5 * FRAME + 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL ovf_drain_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL ovf_drain_status cyc %0d got %h want %h", i, status, m_status()); end
        end
    endtask

    task automatic test_clr_ovf();
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        tests++;
        if (status[3] !== 1'b0) begin fails++; $display("FAIL clr_ovf got %b want 0", status[3]); end
        for (int i = 1; i <= 6; i++) begin
            we = 1'b1; d = 8'(8'h40 + i); clr_ovf = (i == 6); tick();
            tests++;
            if (status !== m_status()) begin fails++; $display("FAIL clr_fill_status wr %0d got %h want %h", i, status, m_status()); end
        end
        we = 1'b0; clr_ovf = 1'b0;
        tests++;
        if (status[3] !== 1'b1) begin fails++; $display("FAIL clr_vs_drop got %b want 1", status[3]); end
        for (int i = 0; i < 5 * FRAME + 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL clr_drain_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL clr_drain_status cyc %0d got %h want %h", i, status, m_status()); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes [3] = '{8'h3C, 8'h5A, 8'h77};
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; d = bytes[i]; tick();
        end
        we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL mid_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL mid_status cyc %0d got %h want %h", i, status, m_status()); end
        end
        #2 reset = 1'b1;
        m_reset();
        #1;
        tests += 2;
        if (tx !== 1'b1) begin fails++; $display("FAIL mid_rst_tx got %b want 1", tx); end
        if (status !== 8'h04) begin fails++; $display("FAIL mid_rst_status got %h want 04", status); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            tests++;
            if (tx !== 1'b1) begin fails++; $display("FAIL mid_post_tx cyc %0d got %b want 1", i, tx); end
        end
        tests++;
        if (status !== 8'h04) begin fails++; $display("FAIL mid_post_status got %h want 04", status); end
    endtask

    task automatic test_random();
        int rate;
        for (int i = 0; i < 3000; i++) begin
            rate = ((i / 200) % 2 == 0) ? 1 : 7;
            we = ($urandom % 8) < rate;
            d = 8'($urandom);
            clr_ovf = ($urandom % 16) == 0;
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL rand_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL rand_status cyc %0d got %h want %h", i, status, m_status()); end
        end
        we = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 5 * FRAME + 10; i++) begin
            tick();
            tests += 2;
            if (tx !== m_tx()) begin fails++; $display("FAIL rand_drain_tx cyc %0d got %b want %b", i, tx, m_tx()); end
            if (status !== m_status()) begin fails++; $display("FAIL rand_drain_status cyc %0d got %h want %h", i, status, m_status()); end
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; d = 8'h00; clr_ovf = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clr_ovf();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
